// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator controller.
// Holds the FSM state encoding and the result-width calculation used by
// csa_accum_ctrl and csa_cell.
package csa_pkg;

  // Legacy-compatible state encoding: plain vector plus named constants.
  typedef logic [1:0] csa_state_t;

  localparam csa_state_t IDLE    = 2'd0;
  localparam csa_state_t ACCUM   = 2'd1;
  localparam csa_state_t RESOLVE = 2'd2;
  localparam csa_state_t DONE    = 2'd3;

  // Result width wide enough for max_ops operands of width bits each.
  function automatic int csa_out_w(input int width, input int max_ops);
    return width + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_cell.sv
// Combinational W-bit 3:2 compressor (carry-save adder cell).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a, b, c operands in; sum = a^b^c; carry = maj(a,b,c) shifted left by one.
module csa_cell #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum = a ^ b ^ c;
  // The carry MSB falls off; the accumulator width already guarantees the
  // exact total never needs it.
  assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator: sums up to MAX_OPS unsigned operands, one 3:2
// compression per accepted operand, then ripples out the carry vector.
// Latency: 1..OUT_W+1 resolve cycles after the last operand; result is held
// in DONE until out_ready, and in_ready stays low from RESOLVE until IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_data/in_last/in_ready
// operand stream; out_valid/out_sum/out_count/out_ready result handshake.
// Optional: define CSA_ACCUM_ERR_EN to add the err output, a registered
// one-cycle pulse flagging operands offered while the block cannot take them.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8,
  localparam int OUT_W  = csa_out_w(WIDTH, MAX_OPS),
  localparam int CNT_W  = $clog2(MAX_OPS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready
`ifdef CSA_ACCUM_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  csa_state_t       state_q, state_d;
  logic [OUT_W-1:0] s_q, s_d;
  logic [OUT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W-1:0] x;
  logic [OUT_W-1:0] cell_sum, cell_carry;
  logic             xfer;

  assign x        = OUT_W'(in_data);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign in_ready = ((state_q == IDLE) || (state_q == ACCUM)) && (cnt_q < MAX_CNT);
  assign xfer     = in_valid && in_ready;

  csa_cell #(.W(OUT_W)) u_cell (
    .a    (s_q),
    .b    (c_q),
    .c    (x),
    .sum  (cell_sum),
    .carry(cell_carry)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          if (state_q == IDLE) begin
            s_d = x;
            c_d = '0;
          end else begin
            s_d = cell_sum;
            c_d = cell_carry;
          end
          cnt_d = cnt_inc;
          // A full operand set closes the sum even without in_last.
          state_d = (in_last || (cnt_inc == MAX_CNT)) ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        // Ripple the redundant form down: S+C is invariant each step and
        // C gains at least one trailing zero, so this ends within OUT_W steps.
        if (c_q == '0) begin
          state_d = DONE;
        end else begin
          s_d = s_q ^ c_q;
          c_d = (s_q & c_q) << 1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? s_q : '0;
  assign out_count = out_valid ? cnt_q : '0;

`ifdef CSA_ACCUM_ERR_EN
  logic err_q, err_d;

  // in_ready is always high in IDLE, so any refused offer outside IDLE counts.
  always_comb begin
    err_d = in_valid && !in_ready && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] out_sum;
  logic [3:0] out_count;
  logic       out_ready;
`ifdef CSA_ACCUM_ERR_EN
  logic       err;
`endif

  csa_accum_ctrl #(.WIDTH(4), .MAX_OPS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ready(out_ready)
`ifdef CSA_ACCUM_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] ops;       // operand i in ops[4*i +: 4]
    logic        use_last;
    int          exp_sum;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Entered and left on a falling edge; the rising edge in between is the transfer.
  task automatic send(input logic [3:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic collect(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 1);
    check({tag, "_sb_pending"}, 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_out_sum"}, 32'(out_sum), 32'(e.sum));
      check({tag, "_out_count"}, 32'(out_count), 32'(e.cnt));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 0);
    check({tag, "_idle_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   bad;
    exp_t e;

    vecs[0] = '{n: 3, ops: 32'h00000FFF, use_last: 1'b1, exp_sum: 45,  exp_cnt: 3};
    vecs[1] = '{n: 1, ops: 32'h00000007, use_last: 1'b1, exp_sum: 7,   exp_cnt: 1};
    vecs[2] = '{n: 8, ops: 32'hFFFFFFFF, use_last: 1'b0, exp_sum: 120, exp_cnt: 8};
    vecs[3] = '{n: 5, ops: 32'h00054321, use_last: 1'b1, exp_sum: 15,  exp_cnt: 5};
    vecs[4] = '{n: 2, ops: 32'h00000000, use_last: 1'b1, exp_sum: 0,   exp_cnt: 2};
    vecs[5] = '{n: 8, ops: 32'h185A3C69, use_last: 1'b1, exp_sum: 54,  exp_cnt: 8};
    vecs[6] = '{n: 2, ops: 32'h0000001F, use_last: 1'b1, exp_sum: 16,  exp_cnt: 2};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_count", 32'(out_count), 0);
`ifdef CSA_ACCUM_ERR_EN
    check("rst_err", 32'(err), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i == vecs[v].n - 1) sb.push_back('{sum: vecs[v].exp_sum, cnt: vecs[v].exp_cnt});
        send(vecs[v].ops[4*i +: 4], vecs[v].use_last && (i == vecs[v].n - 1));
      end
      check($sformatf("vec%0d_ready_drop", v), 32'(in_ready), 0);
      collect($sformatf("vec%0d", v), lat);
      check($sformatf("vec%0d_latency_le10", v), 32'(lat <= 10), 1);
      if (vecs[v].n == 1) check($sformatf("vec%0d_resolve_1cyc", v), 32'(lat), 1);
      repeat (2) @(negedge clk);
    end

    // Result held under backpressure, with a refused offer during DONE.
    sb.push_back('{sum: 11, cnt: 2});
    send(4'd5, 1'b0);
    send(4'd6, 1'b1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold_out_valid", 32'(out_valid), 1);
    e = sb.pop_front();
    check("hold_out_sum", 32'(out_sum), 32'(e.sum));
    check("hold_out_count", 32'(out_count), 32'(e.cnt));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        in_data  = 4'd15;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (!out_valid || out_sum != 7'(e.sum) || out_count != 4'(e.cnt) || in_ready) bad++;
`ifdef CSA_ACCUM_ERR_EN
      if (i == 0) check("err_pulse", 32'(err), 1);
      if (i == 1) check("err_one_cycle", 32'(err), 0);
`endif
    end
    check("hold_stable_cycles_bad", 32'(bad), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release_valid", 32'(out_valid), 0);
    check("hold_release_ready", 32'(in_ready), 1);
    check("hold_release_sum", 32'(out_sum), 0);

    // Reset mid-accumulation discards the partial sum and beats a transfer.
    send(4'd9, 1'b0);
    send(4'd2, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd15;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    sb.push_back('{sum: 7, cnt: 2});
    send(4'd3, 1'b0);
    send(4'd4, 1'b1);
    collect("midrst", lat);

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
